// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input port: buffers an upstream payload, then
// sends header, payload and parity on pkt_valid/data_out and reports the router's err verdict.
module router_pkt_tx #(
  parameter int unsigned ERR_WAIT = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pay_len,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       busy,
  input  logic       err,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       parity_err,
  output logic       cmd_err
);

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ECNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HEADER, S_PAYLOAD, S_PARITY, S_ERRCHK
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] par_q;
  logic [LEN_W-1:0]  wcnt;
  logic [LEN_W-1:0]  rcnt;
  logic [LEN_W-1:0]  rcnt_nx;
  logic [ECNT_W-1:0] ecnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              cmd_ok;
  logic              cmd_go;
  logic              wr_fire;
  logic              xfer;
  logic              last_wr;
  logic              last_rd;
  logic              ecnt_end;

  logic              wr_ready_d;
  logic              pkt_valid_d;
  logic [DATA_W-1:0] data_out_d;
  logic              tx_active_d;
  logic              done_d;
  logic              parity_err_d;
  logic              cmd_err_d;

  assign cmd_ok   = (dest_addr != ADDR_W'(3)) && (pay_len != LEN_W'(0));
  assign cmd_go   = (state == S_IDLE) && start && cmd_ok;
  assign wr_fire  = wr_valid && wr_ready;
  // A byte moves on any edge of a sending state where the router is not busy,
  // including the parity byte which is sent with pkt_valid low.
  assign xfer     = !busy && ((state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY));
  assign last_wr  = (wcnt == len_q - LEN_W'(1));
  assign last_rd  = (rcnt == len_q - LEN_W'(1));
  assign ecnt_end = (ecnt == ECNT_W'(ERR_WAIT - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (cmd_go)                 state_nx = S_FILL;
      S_FILL:    if (wr_fire && last_wr)     state_nx = S_HEADER;
      S_HEADER:  if (xfer)                   state_nx = S_PAYLOAD;
      S_PAYLOAD: if (xfer && last_rd)        state_nx = S_PARITY;
      S_PARITY:  if (xfer)                   state_nx = S_ERRCHK;
      S_ERRCHK:  if (ecnt_end)               state_nx = S_IDLE;
      default:                               state_nx = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the next state
  always_comb begin
    rcnt_nx      = rcnt;
    wr_ready_d   = 1'b0;
    pkt_valid_d  = 1'b0;
    data_out_d   = '0;
    tx_active_d  = (state_nx != S_IDLE);
    done_d       = (state == S_ERRCHK) && ecnt_end;
    cmd_err_d    = (state == S_IDLE) && start && !cmd_ok;
    parity_err_d = parity_err;

    if (state == S_HEADER && xfer)       rcnt_nx = '0;
    else if (state == S_PAYLOAD && xfer) rcnt_nx = rcnt + LEN_W'(1);

    if (cmd_go)                         parity_err_d = 1'b0;
    else if (state == S_ERRCHK && err)  parity_err_d = 1'b1;

    case (state_nx)
      S_FILL:    wr_ready_d = 1'b1;
      S_HEADER: begin
        pkt_valid_d = 1'b1;
        data_out_d  = {len_q, addr_q};
      end
      S_PAYLOAD: begin
        pkt_valid_d = 1'b1;
        data_out_d  = mem[rcnt_nx];
      end
      S_PARITY:  data_out_d = par_q;
      default:   ;
    endcase
  end

  // Output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ready   <= 1'b0;
      pkt_valid  <= 1'b0;
      data_out   <= '0;
      tx_active  <= 1'b0;
      done       <= 1'b0;
      parity_err <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      wr_ready   <= wr_ready_d;
      pkt_valid  <= pkt_valid_d;
      data_out   <= data_out_d;
      tx_active  <= tx_active_d;
      done       <= done_d;
      parity_err <= parity_err_d;
      cmd_err    <= cmd_err_d;
    end
  end

  // Command latch, parity accumulator and counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      len_q  <= '0;
      par_q  <= '0;
      wcnt   <= '0;
      rcnt   <= '0;
      ecnt   <= '0;
    end else begin
      rcnt <= rcnt_nx;
      case (state)
        S_IDLE: if (cmd_go) begin
          addr_q <= dest_addr;
          len_q  <= pay_len;
          par_q  <= {pay_len, dest_addr};
          wcnt   <= '0;
        end
        S_FILL: if (wr_fire) begin
          par_q <= par_q ^ wr_data;
          wcnt  <= wcnt + LEN_W'(1);
        end
        S_PARITY: if (xfer) ecnt <= '0;
        S_ERRCHK: ecnt <= ecnt + ECNT_W'(1);
        default: ;
      endcase
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (state == S_FILL && wr_fire) mem[wcnt] <= wr_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: stimulus pushes expected bytes, a negedge
// monitor pops and compares every byte the router would accept.
module tb_router_pkt_tx;

  localparam int unsigned ERR_WAIT = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] pay_len = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       parity_err;
  logic       cmd_err;

  router_pkt_tx #(.ERR_WAIT(ERR_WAIT)) dut (
    .clock(clock), .reset(reset), .start(start), .dest_addr(dest_addr),
    .pay_len(pay_len), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .err(err), .pkt_valid(pkt_valid), .data_out(data_out),
    .tx_active(tx_active), .done(done), .parity_err(parity_err), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q [$];   // {pkt_valid, data_out}
  logic [7:0] pay [64];
  bit in_pkt = 0;

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_byte(input logic [8:0] act);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_byte: got 0x%0h with empty scoreboard at %0t", act, $time);
    end else begin
      e = exp_q.pop_front();
      chk("tx_byte", act, e);
    end
  endtask

  // Monitor: pkt_valid bytes, then the first non-busy cycle after pkt_valid falls is parity
  always @(negedge clock) begin
    if (reset || !tx_active) in_pkt = 0;
    else if (pkt_valid) begin
      in_pkt = 1;
      if (!busy) mon_byte({1'b1, data_out});
    end else if (in_pkt && !busy) begin
      mon_byte({1'b0, data_out});
      in_pkt = 0;
    end
  end

  task automatic start_cmd(input logic [1:0] a, input logic [5:0] l);
    @(posedge clock); #1;
    start = 1'b1; dest_addr = a; pay_len = l;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Push expected header/payload/parity, then stream the payload in
  task automatic fill(input logic [1:0] a, input logic [5:0] l, input bit hold_hdr);
    logic [7:0] p;
    p = {l, a};
    exp_q.push_back({1'b1, l, a});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back({1'b1, pay[i]});
      p = p ^ pay[i];
    end
    exp_q.push_back({1'b0, p});
    for (int i = 0; i < int'(l); i++) begin
      wr_valid = 1'b1;
      wr_data  = pay[i];
      if (hold_hdr && i == int'(l) - 1) busy = 1'b1;
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
    chk("wr_ready_drop", {8'd0, wr_ready}, 9'd0);
  endtask

  task automatic wait_done(input logic exp_perr);
    bit got;
    got = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clock);
      if (done) got = 1;
    end
    chk("done_seen", {8'd0, got}, 9'd1);
    if (got) begin
      chk("idle_after_done", {8'd0, tx_active}, 9'd0);
      chk("parity_err", {8'd0, parity_err}, {8'd0, exp_perr});
      @(negedge clock);
      chk("done_pulse_1cyc", {8'd0, done}, 9'd0);
    end
    chk("scoreboard_empty", 9'(exp_q.size()), 9'd0);
  endtask

  initial begin
    #3 reset = 1'b1;
    #20;
    chk("rst_pkt_valid", {8'd0, pkt_valid}, 9'd0);
    chk("rst_data_out", {1'b0, data_out}, 9'd0);
    chk("rst_flags", {3'd0, wr_ready, tx_active, done, parity_err, cmd_err, 1'b0}, 9'd0);
    @(negedge clock); reset = 1'b0;

    // Basic 3-byte packet: header 0x0D, parity 0x0D
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    start_cmd(2'd1, 6'd3);
    chk("fill_active", {7'd0, tx_active, wr_ready}, 9'b11);
    fill(2'd1, 6'd3, 1'b0);
    chk("header_value", {pkt_valid, data_out}, 9'h10D);
    wait_done(1'b0);

    // Same packet: busy across the FILL->HEADER edge, then 4 busy cycles on the first payload byte
    start_cmd(2'd1, 6'd3);
    fill(2'd1, 6'd3, 1'b1);
    repeat (2) begin
      @(negedge clock);
      chk("header_hold", {pkt_valid, data_out}, 9'h10D);
    end
    @(posedge clock); #1 busy = 1'b0;
    @(posedge clock); #1 busy = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk("payload_hold", {pkt_valid, data_out}, 9'h111);
      @(posedge clock); #1;
    end
    busy = 1'b0;
    wait_done(1'b0);

    // Maximum length, incrementing data; parity = 0xFE ^ 0x3F = 0xC1
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    start_cmd(2'd2, 6'd63);
    fill(2'd2, 6'd63, 1'b0);
    chk("header_63", {pkt_valid, data_out}, 9'h1FE);
    repeat (64) @(posedge clock);
    #1 chk("parity_63", {pkt_valid, data_out}, 9'h0C1);
    wait_done(1'b0);

    // err in cycle 2 of the check window
    pay[0] = 8'hA5; pay[1] = 8'h5A;
    start_cmd(2'd0, 6'd2);
    fill(2'd0, 6'd2, 1'b0);
    repeat (5) @(posedge clock);
    #1 err = 1'b1;
    @(posedge clock); #1 err = 1'b0;
    wait_done(1'b1);
    chk("perr_held", {8'd0, parity_err}, 9'd1);

    // Next legal start clears parity_err; single-byte payload
    pay[0] = 8'h7E;
    start_cmd(2'd2, 6'd1);
    chk("perr_cleared", {8'd0, parity_err}, 9'd0);
    fill(2'd2, 6'd1, 1'b0);
    wait_done(1'b0);

    // Illegal commands
    start_cmd(2'd3, 6'd5);
    @(negedge clock);
    chk("cmd_err_addr", {6'd0, cmd_err, tx_active, wr_ready}, 9'b100);
    @(negedge clock);
    chk("cmd_err_pulse", {8'd0, cmd_err}, 9'd0);
    start_cmd(2'd1, 6'd0);
    @(negedge clock);
    chk("cmd_err_len", {6'd0, cmd_err, tx_active, wr_ready}, 9'b100);

    // Reset during payload at rcnt=5
    for (int i = 0; i < 8; i++) pay[i] = 8'(8'h40 + i);
    start_cmd(2'd0, 6'd8);
    fill(2'd0, 6'd8, 1'b0);
    repeat (6) @(posedge clock);
    #1 chk("pre_reset_byte", {pkt_valid, data_out}, 9'h145);
    reset = 1'b1;
    #1;
    chk("rst_mid_pkt", {pkt_valid, data_out}, 9'h000);
    chk("rst_mid_active", {8'd0, tx_active}, 9'd0);
    exp_q.delete();
    @(negedge clock); #1 reset = 1'b0;

    // Clean packet after reset
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h04; pay[3] = 8'h08;
    start_cmd(2'd1, 6'd4);
    fill(2'd1, 6'd4, 1'b0);
    chk("header_after_rst", {pkt_valid, data_out}, 9'h111);
    wait_done(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1);
  end

endmodule
